// File: rtl/condition_unit_cl.sv
// Condition-logic stage: holds the NZCV flag register, evaluates the
// instruction condition field against it, qualifies the PCS/RegW/MemW
// strobes and registers them one cycle toward writeback. A saturating
// counter tracks instructions squashed by a failed condition.
module condition_unit_cl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flagw_i,
  input  logic             pcs_i,
  input  logic             regw_i,
  input  logic             memw_i,
  input  logic             nowrite_i,
  input  logic             clr_cnt_i,
  output logic             valid_o,
  output logic             cond_ex_o,
  output logic             pcsrc_o,
  output logic             regwrite_o,
  output logic             memwrite_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] squash_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Architectural flags and registered strobes.
  logic [3:0]       flags_q,    flags_d;
  logic             valid_q,    valid_d;
  logic             cond_ex_q,  cond_ex_d;
  logic             pcsrc_q,    pcsrc_d;
  logic             regwrite_q, regwrite_d;
  logic             memwrite_q, memwrite_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // Combinational condition result; always taken from the held flags so an
  // instruction never sees its own ALU result.
  logic cond_ex;
  logic flag_n, flag_z, flag_c, flag_v;
  logic exec;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Decode the 4-bit condition field against the current flag register.
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_i)
      4'b0000: cond_ex = flag_z;                              // EQ
      4'b0001: cond_ex = ~flag_z;                             // NE
      4'b0010: cond_ex = flag_c;                              // CS
      4'b0011: cond_ex = ~flag_c;                             // CC
      4'b0100: cond_ex = flag_n;                              // MI
      4'b0101: cond_ex = ~flag_n;                             // PL
      4'b0110: cond_ex = flag_v;                              // VS
      4'b0111: cond_ex = ~flag_v;                             // VC
      4'b1000: cond_ex = flag_c & ~flag_z;                    // HI
      4'b1001: cond_ex = ~flag_c | flag_z;                    // LS
      4'b1010: cond_ex = (flag_n == flag_v);                  // GE
      4'b1011: cond_ex = (flag_n != flag_v);                  // LT
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);        // GT
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);         // LE
      4'b1110: cond_ex = 1'b1;                                // AL
      default: cond_ex = 1'b0;                                // NV
    endcase
  end

  assign exec = valid_i & cond_ex;

  // Next-state for flags, strobes and squash counter; stall holds everything.
  always_comb begin
    flags_d    = flags_q;
    valid_d    = valid_q;
    cond_ex_d  = cond_ex_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    cnt_d      = cnt_q;
    if (!stall_i) begin
      valid_d    = valid_i;
      cond_ex_d  = exec;
      pcsrc_d    = exec & pcs_i;
      regwrite_d = exec & regw_i & ~nowrite_i;
      memwrite_d = exec & memw_i;
      // N,Z and C,V have independent write enables; squashed ops write nothing.
      if (exec && flagw_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (exec && flagw_i[0]) flags_d[1:0] = alu_flags_i[1:0];
      // Clear wins over a simultaneous squash; increment saturates.
      if (clr_cnt_i) begin
        cnt_d = '0;
      end else if (valid_i && !cond_ex && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q    <= '0;
      valid_q    <= 1'b0;
      cond_ex_q  <= 1'b0;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      cond_ex_q  <= cond_ex_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      cnt_q      <= cnt_d;
    end
  end

  assign flags_o      = flags_q;
  assign valid_o      = valid_q;
  assign cond_ex_o    = cond_ex_q;
  assign pcsrc_o      = pcsrc_q;
  assign regwrite_o   = regwrite_q;
  assign memwrite_o   = memwrite_q;
  assign squash_cnt_o = cnt_q;

endmodule
